// File: rtl/seq_det_sched.sv
// Round-robin scheduler that time-shares one serial sequence detector among N requesters,
// granting one frame at a time and reporting the per-frame detector hit count to the owner.
module seq_det_sched #(
  parameter int N         = 4,
  parameter int FRAME_LEN = 8,
  parameter int DET_LAT   = 1,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         bit_in,
  output logic [N-1:0]         gnt,
  output logic                 det_rst,
  output logic                 det_x,
  input  logic                 det_y,
  output logic                 done,
  output logic [$clog2(N)-1:0] done_id,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 abort
);

  localparam int ID_W    = $clog2(N);
  localparam int WIN_END = FRAME_LEN + DET_LAT;
  localparam int IDX_W   = $clog2(WIN_END + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic              det_rst_q, det_rst_d;
  logic              abort_q, abort_d;

  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   owner_nxt;
  logic              busy;
  logic              in_win;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    if (hit && (v != {CNT_W{1'b1}})) begin
      return v + 1'b1;
    end
    return v;
  endfunction

  // Scan from the highest offset down so the first requester at or after ptr wins.
  always_comb begin
    logic [ID_W-1:0] j;
    pick_vld = 1'b0;
    pick_id  = '0;
    j        = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = ID_W'((int'(ptr_q) + i) % N);
      if (req[j]) begin
        pick_vld = 1'b1;
        pick_id  = j;
      end
    end
  end

  assign owner_nxt = (owner_q == ID_W'(N - 1)) ? '0 : owner_q + 1'b1;
  assign busy      = (state_q == S_CLR) || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign in_win    = (idx_q >= IDX_W'(DET_LAT));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    done_id_d = done_id_q;
    det_rst_d = 1'b0;
    abort_d   = 1'b0;
    det_x     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d   = pick_id;
          state_d   = S_CLR;
          det_rst_d = 1'b1;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        det_x = bit_in[owner_q];
        if (in_win) cnt_d = sat_inc(cnt_q, det_y);
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
          state_d = (DET_LAT > 0) ? S_DRAIN : S_REPORT;
        end
      end
      S_DRAIN: begin
        if (in_win) cnt_d = sat_inc(cnt_q, det_y);
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(WIN_END - 1)) state_d = S_REPORT;
      end
      S_REPORT: begin
        ptr_d   = owner_nxt;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The count including this cycle's hit is what the owner sees in REPORT.
    if (state_d == S_REPORT) begin
      match_d   = cnt_d;
      done_id_d = owner_q;
    end

    // Owner withdrew mid-frame: release the detector and pass priority on.
    if (busy && !req[owner_q]) begin
      state_d   = S_IDLE;
      abort_d   = 1'b1;
      det_rst_d = 1'b1;
      done_id_d = owner_q;
      ptr_d     = owner_nxt;
      match_d   = match_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      match_q   <= '0;
      done_id_q <= '0;
      det_rst_q <= 1'b1;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      done_id_q <= done_id_d;
      det_rst_q <= det_rst_d;
      abort_q   <= abort_d;
    end
  end

  assign gnt       = busy ? (N'(1) << owner_q) : '0;
  assign det_rst   = det_rst_q;
  assign done      = (state_q == S_REPORT);
  assign done_id   = done_id_q;
  assign match_cnt = match_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: two instances (CNT_W=4 and CNT_W=2) share stimulus, each driving
// its own behavioural overlapping "11" Moore detector; results compared to a frame-level model.
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] bit_in = '0;

  logic [3:0] gnt_a, gnt_b;
  logic       det_rst_a, det_rst_b, det_x_a, det_x_b, det_y_a, det_y_b;
  logic       done_a, done_b, abort_a, abort_b;
  logic [1:0] done_id_a, done_id_b;
  logic [3:0] mcnt_a;
  logic [1:0] mcnt_b;

  seq_det_sched #(.N(4), .FRAME_LEN(8), .DET_LAT(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt_a),
    .det_rst(det_rst_a), .det_x(det_x_a), .det_y(det_y_a), .done(done_a),
    .done_id(done_id_a), .match_cnt(mcnt_a), .abort(abort_a)
  );

  seq_det_sched #(.N(4), .FRAME_LEN(8), .DET_LAT(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt_b),
    .det_rst(det_rst_b), .det_x(det_x_b), .det_y(det_y_b), .done(done_b),
    .done_id(done_id_b), .match_cnt(mcnt_b), .abort(abort_b)
  );

  // Detector: y is high the cycle after two consecutive 1s have been sampled.
  logic prev_a = 1'b0, y_a = 1'b0, prev_b = 1'b0, y_b = 1'b0;
  always_ff @(posedge clk) begin
    if (det_rst_a) begin
      prev_a <= 1'b0;
      y_a    <= 1'b0;
    end else begin
      y_a    <= prev_a & det_x_a;
      prev_a <= det_x_a;
    end
    if (det_rst_b) begin
      prev_b <= 1'b0;
      y_b    <= 1'b0;
    end else begin
      y_b    <= prev_b & det_x_b;
      prev_b <= det_x_b;
    end
  end
  assign det_y_a = y_a;
  assign det_y_b = y_b;

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ptr_m = 0;
  int last_cnt = 0;
  int got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
    end
    return -1;
  endfunction

  function automatic int pairs(input logic [7:0] b);
    int c = 0;
    for (int k = 1; k < 8; k++) if (b[k] && b[k-1]) c++;
    return c;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // mode 0: full frame; mode 1: owner drops req at stream bit at_k; mode 2: rst at stream bit at_k
  task automatic frame(input logic [3:0] reqm, input logic [7:0] fb, input int mode,
                       input int at_k, output int granted);
    int who, waited, c;
    logic [3:0] oh, cur;
    who = pick(reqm);
    oh  = 4'b0001 << who;
    req = reqm;
    waited = 0;
    granted = -1;
    while (gnt_a == 4'b0000 && waited < 4) begin
      @(posedge clk); #1;
      waited++;
      if (gnt_a == 4'b0000) begin
        check("idle_done", {31'b0, done_a}, 0);
        check("idle_abort", {31'b0, abort_a}, 0);
      end
    end
    for (int i = 0; i < 4; i++) if (gnt_a == (4'b0001 << i)) granted = i;
    check("grant", {28'b0, gnt_a}, {28'b0, oh});
    check("grant_b", {28'b0, gnt_b}, {28'b0, oh});
    check("clr_det_rst", {31'b0, det_rst_a}, 1);
    check("clr_det_x", {31'b0, det_x_a}, 0);
    cur = reqm | oh;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      bit_in = 4'($urandom);
      bit_in[who] = fb[k];
      if (mode == 1 && k == at_k) cur = cur & ~oh;
      req = (4'($urandom) & ~oh) | (cur & oh);
      if (mode == 2 && k == at_k) rst = 1'b1;
      #1;
      check("stream_det_x", {31'b0, det_x_a}, {31'b0, fb[k]});
      check("stream_gnt", {28'b0, gnt_a}, {28'b0, oh});
      check("stream_det_rst", {31'b0, det_rst_a}, 0);
      check("stream_done", {31'b0, done_a}, 0);
      if (mode != 0 && k == at_k) begin
        @(posedge clk); #1;
        if (mode == 1) begin
          check("abort_pulse", {31'b0, abort_a}, 1);
          check("abort_no_done", {31'b0, done_a}, 0);
          check("abort_id", {30'b0, done_id_a}, who);
          check("abort_gnt", {28'b0, gnt_a}, 0);
          check("abort_det_rst", {31'b0, det_rst_a}, 1);
          check("abort_keep_cnt", {28'b0, mcnt_a}, sat(last_cnt, 4));
          check("abort_keep_cnt_b", {30'b0, mcnt_b}, sat(last_cnt, 2));
          ptr_m = (who + 1) % 4;
          req = 4'b0000;
          @(posedge clk); #1;
          check("abort_one_cycle", {31'b0, abort_a}, 0);
        end else begin
          check("rst_gnt", {28'b0, gnt_a}, 0);
          check("rst_det_rst", {31'b0, det_rst_a}, 1);
          check("rst_done", {31'b0, done_a}, 0);
          check("rst_abort", {31'b0, abort_a}, 0);
          check("rst_match", {28'b0, mcnt_a}, 0);
          check("rst_done_id", {30'b0, done_id_a}, 0);
          req = 4'b0000;
          @(posedge clk); #1;
          rst = 1'b0;
          ptr_m = 0;
          last_cnt = 0;
        end
        return;
      end
    end
    @(posedge clk); #1;
    bit_in = 4'($urandom);
    #1;
    check("drain_det_x", {31'b0, det_x_a}, 0);
    check("drain_gnt", {28'b0, gnt_a}, {28'b0, oh});
    check("drain_done", {31'b0, done_a}, 0);
    @(posedge clk); #1;
    c = pairs(fb);
    check("report_done", {31'b0, done_a}, 1);
    check("report_done_b", {31'b0, done_b}, 1);
    check("report_id", {30'b0, done_id_a}, who);
    check("report_cnt", {28'b0, mcnt_a}, sat(c, 4));
    check("report_cnt_sat2", {30'b0, mcnt_b}, sat(c, 2));
    check("report_gnt", {28'b0, gnt_a}, 0);
    req = reqm;
    last_cnt = c;
    ptr_m = (who + 1) % 4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", {28'b0, gnt_a}, 0);
    check("reset_det_rst", {31'b0, det_rst_a}, 1);
    check("reset_det_x", {31'b0, det_x_a}, 0);
    check("reset_done", {31'b0, done_a}, 0);
    check("reset_abort", {31'b0, abort_a}, 0);
    check("reset_done_id", {30'b0, done_id_a}, 0);
    check("reset_match", {28'b0, mcnt_a}, 0);
    rst = 1'b0;

    for (int f = 0; f < 5; f++) begin
      frame(4'b1111, 8'($urandom), 0, 0, got);
      check("rr_order", got, order[f]);
    end

    frame(4'b0100, 8'b0111_1011, 0, 0, got);
    check("single_req2_id", got, 2);
    check("single_req2_cnt", {28'b0, mcnt_a}, 4);

    frame(4'b0110, 8'($urandom), 1, 3, got);
    check("drop_owner", got, 1);
    check("drop_hold_cnt", {28'b0, mcnt_a}, 4);
    frame(4'b1111, 8'($urandom), 0, 0, got);
    check("after_abort_grant", got, 2);

    frame(4'b0001, 8'hFF, 0, 0, got);
    check("sat_cnt4", {28'b0, mcnt_a}, 7);
    check("sat_cnt2", {30'b0, mcnt_b}, 3);

    frame(4'b0001, 8'($urandom), 2, 4, got);
    frame(4'b1000, 8'($urandom), 0, 0, got);
    check("post_rst_sole_req3", got, 3);

    for (int r = 0; r < 24; r++) begin
      frame(4'($urandom_range(1, 15)), 8'($urandom),
            ($urandom_range(0, 4) == 0) ? 1 : 0, $urandom_range(0, 7), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
